// File: rtl/regfile_dump_if.sv
// +--------------------------------------------------------------------------+
// | regfile_dump_if : valid/ready beat stream for register-file dump words     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface regfile_dump_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              sum;

    modport master (output valid, data, addr, last, sum, input ready);
    modport slave  (input valid, data, addr, last, sum, output ready);
endinterface

`default_nettype wire

// File: rtl/regfile_dump_ctrl.sv
// +--------------------------------------------------------------------------+
// | regfile_dump_ctrl : walks the register file in pairs and streams every     |
// | word out. Optional trailing XOR checksum beat: REGDUMP_CHECKSUM_EN         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_dump_ctrl #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start,
    output logic [ADDR_W-1:0]      rs,
    output logic [ADDR_W-1:0]      rt,
    input  wire logic [DATA_W-1:0] outR0,
    input  wire logic [DATA_W-1:0] outR1,
    output logic                   busy,
    output logic                   done,
    regfile_dump_if.master         dout
);

    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NUM_REGS / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_SEND0 = 3'd2,
        ST_SEND1 = 3'd3,
        ST_SUM   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rs_q, rs_d;
    logic [ADDR_W-1:0] rt_q, rt_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q, acc_d;
`endif

    assign rs = rs_q;
    assign rt = rt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rs_q    <= '0;
            rt_q    <= '0;
            k_q     <= '0;
            buf0_q  <= '0;
            buf1_q  <= '0;
`ifdef REGDUMP_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            k_q     <= k_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
`ifdef REGDUMP_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        k_d        = k_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
`ifdef REGDUMP_CHECKSUM_EN
        acc_d      = acc_q;
`endif
        busy       = 1'b0;
        done       = 1'b0;
        dout.valid = 1'b0;
        dout.data  = '0;
        dout.addr  = '0;
        dout.last  = 1'b0;
        dout.sum   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    rs_d    = '0;
                    rt_d    = ADDR_W'(1);
                    k_d     = '0;
`ifdef REGDUMP_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            // Both read ports are sampled here; later writes cannot reach the beats
            ST_ISSUE: begin
                busy    = 1'b1;
                buf0_d  = outR0;
                buf1_d  = outR1;
                state_d = ST_SEND0;
            end
            ST_SEND0: begin
                busy       = 1'b1;
                dout.valid = 1'b1;
                dout.data  = buf0_q;
                dout.addr  = rs_q;
                if (dout.ready) begin
                    state_d = ST_SEND1;
`ifdef REGDUMP_CHECKSUM_EN
                    acc_d   = acc_q ^ buf0_q;
`endif
                end
            end
            ST_SEND1: begin
                busy       = 1'b1;
                dout.valid = 1'b1;
                dout.data  = buf1_q;
                dout.addr  = rt_q;
`ifndef REGDUMP_CHECKSUM_EN
                dout.last  = (k_q == LAST_K);
`endif
                if (dout.ready) begin
`ifdef REGDUMP_CHECKSUM_EN
                    acc_d = acc_q ^ buf1_q;
`endif
                    if (k_q == LAST_K) begin
`ifdef REGDUMP_CHECKSUM_EN
                        state_d = ST_SUM;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        k_d     = k_q + ADDR_W'(1);
                        rs_d    = rs_q + ADDR_W'(2);
                        rt_d    = rt_q + ADDR_W'(2);
                        state_d = ST_ISSUE;
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            ST_SUM: begin
                busy       = 1'b1;
                dout.valid = 1'b1;
                dout.data  = acc_q;
                dout.sum   = 1'b1;
                dout.last  = 1'b1;
                if (dout.ready) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_regfile_dump_ctrl : directed self-checking bench for regfile_dump_ctrl |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_dump_ctrl;

    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int NB     = NUM_REGS + 1;
    localparam int DONE_C = 13;
`else
    localparam int NB     = NUM_REGS;
    localparam int DONE_C = 12;   // DONE is the 13th cycle after the accepting edge
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] rs, rt;
    logic [DATA_W-1:0] outR0, outR1;
    logic              busy, done;
    logic [DATA_W-1:0] rf    [NUM_REGS];
    logic [DATA_W-1:0] exp_d [NUM_REGS];
    int                n_cmp = 0;
    int                n_err = 0;

    regfile_dump_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dif ();

    regfile_dump_ctrl #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .rs    (rs),
        .rt    (rt),
        .outR0 (outR0),
        .outR1 (outR1),
        .busy  (busy),
        .done  (done),
        .dout  (dif)
    );

    always #5 clk = ~clk;

    assign outR0 = rf[rs];
    assign outR1 = rf[rt];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic load(input int base);
        for (int i = 0; i < NUM_REGS; i++) begin
            rf[i]    = DATA_W'(base + i);
            exp_d[i] = DATA_W'(base + i);
        end
    endtask

    task automatic run_dump(input string tag, input int stall_beat, input int stall_n,
                            input bit restart, input bit poke);
        int                nb;
        int                stalls;
        int                c;
        int                done_c;
        int                first_c;
        logic [DATA_W-1:0] acc;
        logic [DATA_W-1:0] e_data;
        logic [ADDR_W-1:0] e_addr;
        logic              e_last;
        logic              e_sum;
        nb = 0; stalls = stall_n; c = 0; done_c = -1; first_c = -1; acc = '0;
        dif.ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "/issue_valid"}, dif.valid, 0);
        check({tag, "/issue_busy"},  busy, 1);
        check({tag, "/issue_rs"},    rs, 0);
        check({tag, "/issue_rt"},    rt, 1);
        while (done_c < 0 && c < 80) begin
            step();
            c++;
            start = 1'b0;
            if (done) begin
                done_c = c;
                check({tag, "/done_valid"}, dif.valid, 0);
            end else if (dif.valid) begin
                if (first_c < 0) first_c = c;
                if (nb < NUM_REGS) begin
                    e_data = exp_d[nb];
                    e_addr = nb[ADDR_W-1:0];
                    e_sum  = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                    e_last = 1'b0;
`else
                    e_last = (nb == NUM_REGS - 1);
`endif
                end else begin
                    e_data = acc;
                    e_addr = '0;
                    e_sum  = 1'b1;
                    e_last = 1'b1;
                end
                check({tag, "/data"}, dif.data, e_data);
                check({tag, "/addr"}, dif.addr, e_addr);
                check({tag, "/last"}, dif.last, e_last);
                check({tag, "/sum"},  dif.sum,  e_sum);
                if (poke && nb == 4) rf[5] = 16'hBEEF;
                if (nb == stall_beat && stalls > 0) begin
                    dif.ready = 1'b0;
                    stalls--;
                end else begin
                    dif.ready = 1'b1;
                end
                if (dif.ready) begin
                    if (nb < NUM_REGS) acc = acc ^ e_data;
                    nb++;
                end
                if (restart && nb == 2) start = 1'b1;
            end
        end
        dif.ready = 1'b1;
        check({tag, "/first_valid_cycle"}, first_c, 1);
        check({tag, "/done_cycle"}, done_c, DONE_C + stall_n);
        check({tag, "/beats"}, nb, NB);
        if (restart) start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "/post_done"},  done, 0);
        check({tag, "/post_busy"},  busy, 0);
        check({tag, "/post_valid"}, dif.valid, 0);
        repeat (3) step();
        check({tag, "/idle_busy"},  busy, 0);
        check({tag, "/idle_valid"}, dif.valid, 0);
    endtask

    initial begin
        int c;
        bit found;
        bit seen;
        reset     = 1'b1;
        start     = 1'b0;
        dif.ready = 1'b1;
        load(0);
        step();
        step();
        check("reset/valid", dif.valid, 0);
        check("reset/rs",    rs, 0);
        check("reset/rt",    rt, 0);
        check("reset/busy",  busy, 0);
        check("reset/done",  done, 0);
        check("reset/data",  dif.data, 0);
        check("reset/addr",  dif.addr, 0);
        check("reset/last",  dif.last, 0);
        check("reset/sum",   dif.sum, 0);
        reset = 1'b0;
        step();

        run_dump("basic", -1, 0, 1'b0, 1'b0);
        run_dump("backpressure", 3, 3, 1'b0, 1'b0);
        run_dump("start_busy", -1, 0, 1'b1, 1'b0);
        run_dump("capture", -1, 0, 1'b0, 1'b1);
        check("capture/rf_written", rf[5], 16'hBEEF);
        load(0);

        // Abort while beat addr 3 (SEND1 of pair 1) is on the bus
        start = 1'b1;
        step();
        start = 1'b0;
        c = 0;
        found = 1'b0;
        while (!found && c < 20) begin
            step();
            c++;
            if (dif.valid && dif.addr == 3) found = 1'b1;
        end
        check("rst_mid/reached", found, 1);
        reset = 1'b1;
        step();
        check("rst_mid/valid", dif.valid, 0);
        check("rst_mid/rs",    rs, 0);
        check("rst_mid/rt",    rt, 0);
        check("rst_mid/busy",  busy, 0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            step();
            if (done || dif.valid) seen = 1'b1;
        end
        check("rst_mid/quiet", seen, 0);
        run_dump("after_reset", -1, 0, 1'b0, 1'b0);

        load(1);
        run_dump("checksum", -1, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
